// File: rtl/wave_color_pkg.sv
// Shared types and constants for the trace-color controller.
package wave_color_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        AUTO    = 2'd2
    } state_t;

    localparam logic [3:0] KEY_NEXT = 4'd8;
    localparam logic [3:0] KEY_PREV = 4'd9;
    localparam int         HUE_MAX  = 1536;

    localparam logic [2:0]  RESET_IDX    = 3'd2;
    localparam logic [23:0] HUE_ZERO_RGB = 24'hFF0000;

    // Entry 0 is the rightmost element.
    localparam logic [7:0][23:0] PRESET_RGB = {
        24'hFF8000, 24'hFF00FF, 24'h00FFFF, 24'hFFFF00,
        24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hFFFFFF
    };

    // Maps a key code to a preset index; 8/9 step relative to base.
    function automatic logic [2:0] key_idx(input logic [3:0] key, input logic [2:0] base);
        if (key == KEY_NEXT)      return base + 3'd1;
        else if (key == KEY_PREV) return base - 3'd1;
        else                      return key[2:0];
    endfunction

endpackage

// File: rtl/wave_color_ctrl_hue.sv
// Combinational hue wheel: 11-bit phase (0..1535) to 24-bit RGB.
module hue_to_rgb (
    input  logic [10:0] phase,
    output logic [23:0] rgb
);
    logic [2:0] sector;
    logic [7:0] f;

    assign sector = phase[10:8];
    assign f      = phase[7:0];

    always_comb begin
        rgb = 24'hFF0000;
        case (sector)
            3'd0: rgb = {8'hFF,     f,         8'h00};
            3'd1: rgb = {8'hFF - f, 8'hFF,     8'h00};
            3'd2: rgb = {8'h00,     8'hFF,     f};
            3'd3: rgb = {8'h00,     8'hFF - f, 8'hFF};
            3'd4: rgb = {f,         8'h00,     8'hFF};
            3'd5: rgb = {8'hFF,     8'h00,     8'hFF - f};
            default: rgb = 24'hFF0000;
        endcase
    end
endmodule

// File: rtl/wave_color_ctrl.sv
// Trace-color controller: color changes land only at blanking start.
// Optional hue fade compiled in with `define WAVE_COLOR_AUTO_EN.
module wave_color_ctrl
    import wave_color_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 4,
    parameter int STEP            = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] keypad_value,
    input  logic       ready,
    input  logic       switch,
    input  logic       vsync,
    output logic       color_changing,
    output logic [7:0] trace_r,
    output logic [7:0] trace_g,
    output logic [7:0] trace_b
);
    state_t      state, state_nx;
    logic [2:0]  cur_idx, cur_nx;
    logic [2:0]  pend_idx, pend_nx, pend_eff;
    logic [23:0] rgb, rgb_nx;
    logic        vsync_q;
    logic        blank_start;
    logic        key_ok;

    assign blank_start = vsync_q & ~vsync;
    assign key_ok      = ready && (keypad_value <= KEY_PREV);
    assign pend_eff    = key_ok ? key_idx(keypad_value, pend_idx) : pend_idx;

    assign {trace_r, trace_g, trace_b} = rgb;

`ifdef WAVE_COLOR_AUTO_EN
    localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    logic [10:0]   phase, phase_nx, phase_adv;
    logic [11:0]   phase_sum;
    logic [FW-1:0] fcnt, fcnt_nx;
    logic [23:0]   hue_adv;

    assign phase_sum = {1'b0, phase} + 12'(STEP);
    assign phase_adv = (phase_sum >= 12'(HUE_MAX)) ? 11'(phase_sum - 12'(HUE_MAX))
                                                   : phase_sum[10:0];

    hue_to_rgb u_hue (
        .phase (phase_adv),
        .rgb   (hue_adv)
    );
`else
    logic unused_switch;
    assign unused_switch = switch;
`endif

    always_comb begin
        state_nx = state;
        cur_nx   = cur_idx;
        pend_nx  = pend_idx;
        rgb_nx   = rgb;
`ifdef WAVE_COLOR_AUTO_EN
        phase_nx = phase;
        fcnt_nx  = fcnt;
`endif
        case (state)
            IDLE: begin
                // A key arriving with blank start waits for the next blank.
                if (key_ok) begin
                    pend_nx  = key_idx(keypad_value, cur_idx);
                    state_nx = PENDING;
                end
`ifdef WAVE_COLOR_AUTO_EN
                else if (blank_start && switch) begin
                    state_nx = AUTO;
                    phase_nx = '0;
                    fcnt_nx  = '0;
                    rgb_nx   = HUE_ZERO_RGB;
                end
`endif
            end
            PENDING: begin
                pend_nx = pend_eff;
                if (blank_start) begin
                    cur_nx   = pend_eff;
                    rgb_nx   = PRESET_RGB[pend_eff];
                    state_nx = IDLE;
`ifdef WAVE_COLOR_AUTO_EN
                    if (switch) begin
                        state_nx = AUTO;
                        phase_nx = '0;
                        fcnt_nx  = '0;
                    end
`endif
                end
            end
`ifdef WAVE_COLOR_AUTO_EN
            AUTO: begin
                if (blank_start) begin
                    if (!switch) begin
                        state_nx = IDLE;
                        rgb_nx   = PRESET_RGB[cur_idx];
                    end else if (fcnt == FW'(FRAMES_PER_STEP - 1)) begin
                        fcnt_nx  = '0;
                        phase_nx = phase_adv;
                        rgb_nx   = hue_adv;
                    end else begin
                        fcnt_nx  = fcnt + 1'b1;
                    end
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            color_changing <= 1'b0;
            cur_idx        <= RESET_IDX;
            pend_idx       <= RESET_IDX;
            rgb            <= PRESET_RGB[RESET_IDX];
            vsync_q        <= 1'b1;
`ifdef WAVE_COLOR_AUTO_EN
            phase          <= '0;
            fcnt           <= '0;
`endif
        end else begin
            state          <= state_nx;
            color_changing <= (state_nx != IDLE);
            cur_idx        <= cur_nx;
            pend_idx       <= pend_nx;
            rgb            <= rgb_nx;
            vsync_q        <= vsync;
`ifdef WAVE_COLOR_AUTO_EN
            phase          <= phase_nx;
            fcnt           <= fcnt_nx;
`endif
        end
    end
endmodule

// File: tb/tb_wave_color_ctrl.sv
// Directed bench for wave_color_ctrl; fade checks need WAVE_COLOR_AUTO_EN.
module tb_wave_color_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] keypad_value = 4'd0;
    logic       ready = 1'b0;
    logic       switch = 1'b0;
    logic       vsync = 1'b1;
    logic       color_changing;
    logic [7:0] trace_r, trace_g, trace_b;

    int checks = 0;
    int errors = 0;

    wave_color_ctrl #(.FRAMES_PER_STEP(2), .STEP(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .keypad_value   (keypad_value),
        .ready          (ready),
        .switch         (switch),
        .vsync          (vsync),
        .color_changing (color_changing),
        .trace_r        (trace_r),
        .trace_g        (trace_g),
        .trace_b        (trace_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] rgb();
        return {trace_r, trace_g, trace_b};
    endfunction

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        keypad_value = k;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    // One low cycle of vsync, then back to active video.
    task automatic do_blank();
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_rgb", 32'(rgb()), 32'h00FF00);
        chk("reset_cc", 32'(color_changing), 32'h0);

        press(4'd3);
        chk("key3_cc", 32'(color_changing), 32'h1);
        chk("key3_hold", 32'(rgb()), 32'h00FF00);
        repeat (5) @(negedge clk);
        chk("key3_hold_active", 32'(rgb()), 32'h00FF00);
        do_blank();
        chk("key3_commit", 32'(rgb()), 32'h0000FF);
        chk("key3_cc_clr", 32'(color_changing), 32'h0);

        press(4'd1);
        press(4'd5);
        do_blank();
        chk("last_wins", 32'(rgb()), 32'h00FFFF);

        press(4'd0);
        do_blank();
        chk("key0", 32'(rgb()), 32'hFFFFFF);
        press(4'd9);
        do_blank();
        chk("prev_wrap", 32'(rgb()), 32'hFF8000);
        press(4'd8);
        do_blank();
        chk("next_wrap", 32'(rgb()), 32'hFFFFFF);

        press(4'hA);
        chk("keyA_ignored", 32'(color_changing), 32'h0);

        // key coincident with blank start in IDLE
        @(negedge clk);
        vsync = 1'b0; ready = 1'b1; keypad_value = 4'd4;
        @(negedge clk);
        vsync = 1'b1; ready = 1'b0;
        chk("idle_coinc_hold", 32'(rgb()), 32'hFFFFFF);
        chk("idle_coinc_cc", 32'(color_changing), 32'h1);
        @(negedge clk);
        do_blank();
        chk("idle_coinc_next", 32'(rgb()), 32'hFFFF00);

        // key coincident with blank start in PENDING
        press(4'd1);
        @(negedge clk);
        vsync = 1'b0; ready = 1'b1; keypad_value = 4'd6;
        @(negedge clk);
        vsync = 1'b1; ready = 1'b0;
        @(negedge clk);
        chk("pend_coinc", 32'(rgb()), 32'hFF00FF);
        chk("pend_coinc_cc", 32'(color_changing), 32'h0);

`ifdef WAVE_COLOR_AUTO_EN
        switch = 1'b1;
        do_blank();
        chk("auto_entry", 32'(rgb()), 32'hFF0000);
        chk("auto_cc", 32'(color_changing), 32'h1);
        do_blank();
        chk("auto_1frame", 32'(rgb()), 32'hFF0000);
        do_blank();
        chk("auto_2frames", 32'(rgb()), 32'hFF0800);
        press(4'd2);
        chk("auto_key_drop", 32'(rgb()), 32'hFF0800);
        chk("auto_key_cc", 32'(color_changing), 32'h1);
        repeat (2) do_blank();
        chk("auto_4frames", 32'(rgb()), 32'hFF1000);
        repeat (96) do_blank();
        chk("auto_phase400", 32'(rgb()), 32'h6FFF00);
        repeat (282) do_blank();
        chk("auto_phase1528", 32'(rgb()), 32'hFF0007);
        repeat (2) do_blank();
        chk("auto_wrap", 32'(rgb()), 32'hFF0000);
        switch = 1'b0;
        do_blank();
        chk("auto_exit", 32'(rgb()), 32'hFF00FF);
        chk("auto_exit_cc", 32'(color_changing), 32'h0);
        switch = 1'b1;
        repeat (3) do_blank();
        chk("auto_reenter", 32'(rgb()), 32'hFF0800);
`else
        switch = 1'b1;
        repeat (3) do_blank();
        chk("switch_ignored", 32'(rgb()), 32'hFF00FF);
        chk("switch_ignored_cc", 32'(color_changing), 32'h0);
        press(4'd1);
`endif
        // asynchronous reset mid-fade / mid-pending
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_rst_rgb", 32'(rgb()), 32'h00FF00);
        chk("async_rst_cc", 32'(color_changing), 32'h0);
        switch = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        do_blank();
        chk("post_rst_idle", 32'(rgb()), 32'h00FF00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wave_color_ctrl.md
# wave_color_ctrl

Trace-color controller for the oscilloscope display path. Takes keypad presses and the auto-mode switch, sequences color changes so they only take effect at the start of vertical blanking (no mid-frame tearing), and optionally runs a frame-paced hue fade. Its registered RGB feeds the wave renderer's trace color, and its `color_changing` flag drives the status LED.

## Interface
- `FRAMES_PER_STEP`, default 4: blanking intervals per fade step, at least 1.
- `STEP`, default 8: hue phase increment per fade step, range 1..255.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `keypad_value` input 4: key code, valid only when `ready`=1.
- `ready` input 1: one-cycle pulse marking a new key press.
- `switch` input 1: auto-fade mode request (level).
- `vsync` input 1: high during active display, low during blanking.
- `color_changing` output 1: high while a change is pending or a fade is running.
- `trace_r`, `trace_g`, `trace_b` output 8 each: committed trace color.

## Operation
- Presets, indexed 0..7:
  - 0 FFFFFF, 1 FF0000, 2 00FF00, 3 0000FF
  - 4 FFFF00, 5 00FFFF, 6 FF00FF, 7 FF8000
- Blank start: `blank_start` = `vsync_q & ~vsync`, where `vsync_q` is `vsync` registered.
- IDLE state:
  - `ready` with key 0..7 latches that preset index into `pend_idx`; go to PENDING.
  - Key 8 latches committed index +1, key 9 latches committed index −1, both mod 8; go to PENDING.
  - Keys A..F are ignored.
  - `switch`=1 sampled at `blank_start` → AUTO; phase=0, frame count=0.
- PENDING state:
  - Further valid keys overwrite `pend_idx` (last wins). Keys 8/9 step relative to `pend_idx`.
  - At `blank_start`, commit `pend_idx`, load the preset color, go to IDLE.
  - If `switch`=1 at that same `blank_start`, commit the preset and go to AUTO instead.
- AUTO state:
  - Keys are dropped.
  - Each `blank_start` increments the frame count. When the count reaches `FRAMES_PER_STEP`−1, the count clears and phase advances by `STEP`.
  - Phase is 11 bits, range 0..1535. If phase+`STEP` ≥ 1536, subtract 1536.
  - Outputs = `hue_to_rgb(phase)` for the new phase.
  - `switch`=0 at `blank_start` → commit the committed preset index's color, go to IDLE.
- Hue mapping uses sector = `phase[10:8]` and f = `phase[7:0]`:
  - Sector 0: (FF, f, 0)
  - Sector 1: (FF−f, FF, 0)
  - Sector 2: (0, FF, f)
  - Sector 3: (0, FF−f, FF)
  - Sector 4: (f, 0, FF)
  - Sector 5: (FF, 0, FF−f)
- `color_changing` = (state≠IDLE), registered together with the state.

## Timing
- Reset values:
  - state IDLE, committed index 2, `pend_idx` 2, phase 0, frame count 0, `vsync_q` 1.
  - Outputs 00,FF,00; `color_changing` 0.
- Key press: `ready` at edge k → PENDING and `color_changing`=1 after edge k.
- Commit latency: RGB changes at the edge where `blank_start` is true. The new color is visible from the first cycle after `vsync` is first sampled low.
- `ready` coincident with `blank_start` in IDLE: the key is latched to PENDING and applied at the next `blank_start`, not the current one.
- `ready` coincident with `blank_start` in PENDING: the new key overwrites `pend_idx` first, then commits in the same edge.
- Outputs never change while `vsync`=1, except through reset.
- Reset asserted mid-fade or mid-pending returns to reset values immediately, asynchronously.

## Configuration
- `WAVE_COLOR_AUTO_EN`
  - Defined: AUTO state, phase and frame counters, and the `hue_to_rgb` instance are compiled in.
  - Undefined: `switch` is ignored, AUTO is unreachable, and the fade logic is absent. `color_changing` only reflects PENDING.

## Structure
- Shared package `wave_color_pkg` holds:
  - state enum (IDLE, PENDING, AUTO)
  - 8-entry preset RGB constant table
  - key codes `KEY_NEXT`=8, `KEY_PREV`=9
  - `HUE_MAX`=1536
- Sub-module `hue_to_rgb`: purely combinational, 11-bit phase in, 24-bit RGB out.

## Test plan
- Reset → outputs 00FF00, `color_changing`=0. Key 3 during active video → `color_changing`=1, RGB holds 00FF00 until `vsync` falls, then 0000FF.
- Keys 1 then 5 within one frame → single commit of 00FFFF at blank start (last wins).
- Key 9 from committed index 0 → commits index 7, FF8000. Key 8 from 7 → commits index 0, FFFFFF.
- `ready` and `blank_start` in the same cycle from IDLE with key 4 → no change this blank start; FFFF00 at the next.
- `switch`=1, `FRAMES_PER_STEP`=2, `STEP`=8:
  - RGB FF0000 at entry.
  - FF0800 after 2 further blank starts, FF1000 after 4.
  - Phase 1528+8 wraps to 0 (FF0000).
  - Keys ignored throughout.
- Reset asserted mid-fade → immediate 00FF00 and IDLE. With `WAVE_COLOR_AUTO_EN` undefined, `switch`=1 has no effect.
